n64_pi_host: RTL and testbench

N64_PI_HOST -- requirements
Module: n64_pi_host

---
 rtl/n64_pi_host_if.sv | 34 +++
 rtl/n64_pi_host.sv | 154 +++++++++++++++
 tb/tb_n64_pi_host.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/n64_pi_host_if.sv
// Host-side bundle for the N64 parallel-interface master: request/handshake
// signals toward the core plus the split AD bus toward the cartridge.
interface n64_pi_host_if;
    logic        req;
    logic        busy;
    logic        done;
    logic        write;
    logic [31:0] address;
    logic [7:0]  length;
    logic [15:0] wdata;
    logic        wdata_valid;
    logic        wdata_ready;
    logic [15:0] rdata;
    logic        rdata_valid;
    logic        pi_aleh;
    logic        pi_alel;
    logic        pi_read_n;
    logic        pi_write_n;
    logic        pi_ad_oe;
    logic [15:0] pi_ad_out;
    logic [15:0] pi_ad_in;

    modport master (
        input  req, write, address, length, wdata, wdata_valid, pi_ad_in,
        output busy, done, wdata_ready, rdata, rdata_valid,
               pi_aleh, pi_alel, pi_read_n, pi_write_n, pi_ad_oe, pi_ad_out
    );

    modport slave (
        output req, write, address, length, wdata, wdata_valid, pi_ad_in,
        input  busy, done, wdata_ready, rdata, rdata_valid,
               pi_aleh, pi_alel, pi_read_n, pi_write_n, pi_ad_oe, pi_ad_out
    );
endinterface

// File: rtl/n64_pi_host.sv
// N64 PI bus master: address phases, settle, then a burst of strobed 16-bit words.
// Bus pins are registered from the next state so strobes never glitch; writes stall in VALID mode until a word is offered.
module n64_pi_host #(
    parameter int ALE_CYCLES     = 4,
    parameter int LATENCY_CYCLES = 16,
    parameter int PULSE_CYCLES   = 8,
    parameter int RELEASE_CYCLES = 4
) (
    input  logic          clk,
    input  logic          reset,
    n64_pi_host_if.master bus
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] ADDR_H  = 3'd1;
    localparam logic [2:0] ADDR_L  = 3'd2;
    localparam logic [2:0] SETTLE  = 3'd3;
    localparam logic [2:0] STROBE  = 3'd4;
    localparam logic [2:0] RELEASE = 3'd5;
    localparam logic [2:0] FINISH  = 3'd6;

    // Phase counters compare against "cycles - 1"; a zero parameter behaves as one cycle.
    localparam logic [7:0] ALE_LAST   = (ALE_CYCLES     > 1) ? 8'(ALE_CYCLES - 1)     : 8'd0;
    localparam logic [7:0] LAT_LAST   = (LATENCY_CYCLES > 1) ? 8'(LATENCY_CYCLES - 1) : 8'd0;
    localparam logic [7:0] PULSE_LAST = (PULSE_CYCLES   > 1) ? 8'(PULSE_CYCLES - 1)   : 8'd0;
    localparam logic [7:0] REL_LAST   = (RELEASE_CYCLES > 1) ? 8'(RELEASE_CYCLES - 1) : 8'd0;

    logic [2:0]  state, state_nx;
    logic [7:0]  cnt, cnt_nx;
    logic [7:0]  wcnt, wcnt_nx;
    logic        write_q;
    logic [15:1] addr_lo_q;
    logic [7:0]  len_q;
    logic        accept, last_word, wready, wr_take, rd_sample;

    logic        aleh_q, alel_q, read_n_q, write_n_q, oe_q, busy_q, done_q, rvalid_q;
    logic [15:0] ad_out_q, rdata_q;

    assign accept    = (state == IDLE) && bus.req;
    assign last_word = (wcnt == len_q);
    assign wready    = write_q && (((state == SETTLE)  && (cnt == LAT_LAST)) ||
                                   ((state == RELEASE) && (cnt == REL_LAST) && !last_word));
    assign wr_take   = wready && bus.wdata_valid;
    assign rd_sample = (state == STROBE) && (cnt == PULSE_LAST) && !write_q;

    // wcnt indexes the word in flight; it advances as the next strobe begins, so length=255 never wraps.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt + 8'd1;
        wcnt_nx  = wcnt;
        case (state)
            IDLE: begin
                cnt_nx = 8'd0;
                if (bus.req) begin
                    state_nx = ADDR_H;
                    wcnt_nx  = 8'd0;
                end
            end
            ADDR_H: if (cnt == ALE_LAST) begin
                state_nx = ADDR_L;
                cnt_nx   = 8'd0;
            end
            ADDR_L: if (cnt == ALE_LAST) begin
                state_nx = SETTLE;
                cnt_nx   = 8'd0;
            end
            SETTLE: if (cnt == LAT_LAST) begin
                cnt_nx = cnt;
                if (!write_q || bus.wdata_valid) begin
                    state_nx = STROBE;
                    cnt_nx   = 8'd0;
                end
            end
            STROBE: if (cnt == PULSE_LAST) begin
                state_nx = RELEASE;
                cnt_nx   = 8'd0;
            end
            RELEASE: if (cnt == REL_LAST) begin
                cnt_nx = cnt;
                if (last_word) begin
                    state_nx = FINISH;
                    cnt_nx   = 8'd0;
                end else if (!write_q || bus.wdata_valid) begin
                    state_nx = STROBE;
                    cnt_nx   = 8'd0;
                    wcnt_nx  = wcnt + 8'd1;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= 8'd0;
            wcnt      <= 8'd0;
            write_q   <= 1'b0;
            addr_lo_q <= '0;
            len_q     <= 8'd0;
            aleh_q    <= 1'b1;
            alel_q    <= 1'b0;
            read_n_q  <= 1'b1;
            write_n_q <= 1'b1;
            oe_q      <= 1'b0;
            ad_out_q  <= 16'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= 16'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            wcnt  <= wcnt_nx;
            if (accept) begin
                write_q   <= bus.write;
                addr_lo_q <= bus.address[15:1];
                len_q     <= bus.length;
            end
            aleh_q    <= (state_nx == IDLE) || (state_nx == ADDR_H) || (state_nx == FINISH);
            alel_q    <= (state_nx == ADDR_H) || (state_nx == ADDR_L);
            read_n_q  <= !((state_nx == STROBE) && !write_q);
            write_n_q <= !((state_nx == STROBE) && write_q);
            oe_q      <= (state_nx == ADDR_H) || (state_nx == ADDR_L) ||
                         (write_q && ((state_nx == SETTLE) || (state_nx == STROBE) || (state_nx == RELEASE)));
            // The address goes out once; the cartridge auto-increments it across the burst.
            if (accept)
                ad_out_q <= bus.address[31:16];
            else if ((state == ADDR_H) && (state_nx == ADDR_L))
                ad_out_q <= {addr_lo_q, 1'b0};
            else if (wr_take)
                ad_out_q <= bus.wdata;
            busy_q   <= (state_nx != IDLE) && (state_nx != FINISH);
            done_q   <= (state_nx == FINISH);
            rvalid_q <= rd_sample;
            if (rd_sample)
                rdata_q <= bus.pi_ad_in;
        end
    end

    assign bus.pi_aleh     = aleh_q;
    assign bus.pi_alel     = alel_q;
    assign bus.pi_read_n   = read_n_q;
    assign bus.pi_write_n  = write_n_q;
    assign bus.pi_ad_oe    = oe_q;
    assign bus.pi_ad_out   = ad_out_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.wdata_ready = wready;
    assign bus.rdata_valid = rvalid_q;
    assign bus.rdata       = rdata_q;
endmodule

// File: tb/tb_n64_pi_host.sv
// Bench for n64_pi_host: a cartridge-side monitor/responder records each burst and
// results are compared against expectations derived from the bus protocol rules.
module tb_n64_pi_host;
    localparam int ALE = 4, LAT = 16, PUL = 8, REL = 4, TMO = 20000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    n64_pi_host_if bus();

    n64_pi_host dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] a;
        logic [7:0]  len;
        int          sw;
        int          st;
        logic        busy_pulse;
        logic [15:0] exp_hi;
        logic [15:0] exp_lo;
    } vec_t;
    vec_t vecs[6];

    // Cartridge-side observer: per-burst statistics, cleared when mon_clr is seen.
    logic        mon_clr = 1'b0;
    int          hi_cyc, lo_cyc, pre_cyc, gap_sum, cur_gap, post_cyc, strb, cur_w;
    int          width_bad, bad_mode, done_cnt, oe_bad, wunstable, rsrc_i;
    logic [15:0] hi_val, lo_val;
    logic [1:0]  pmode = 2'b10;
    logic        strb_p = 1'b0, pulse_rd = 1'b0;
    logic [15:0] wobs[$], robs[$], rsrc[$], wsrc[$];

    always @(negedge clk) begin
        logic [1:0] mode;
        logic       s;
        mode = {bus.pi_aleh, bus.pi_alel};
        s    = !bus.pi_read_n || !bus.pi_write_n;
        if (mon_clr) begin
            hi_cyc = 0; lo_cyc = 0; pre_cyc = 0; gap_sum = 0; cur_gap = 0; post_cyc = 0;
            strb = 0; cur_w = 0; width_bad = 0; bad_mode = 0; done_cnt = 0; oe_bad = 0;
            wunstable = 0; rsrc_i = 0; hi_val = 16'hxxxx; lo_val = 16'hxxxx;
            wobs.delete(); robs.delete();
        end
        if (!reset) begin
            pmode = 2'b10; strb_p = 1'b0; bus.pi_ad_in = 16'h0000;
        end else begin
            if (mode != pmode && !((pmode == 2'b10 && mode == 2'b11) || (pmode == 2'b11 && mode == 2'b01) ||
                                   (pmode == 2'b01 && mode == 2'b00) || (pmode == 2'b00 && mode == 2'b10)))
                bad_mode++;
            if (mode == 2'b11) begin hi_cyc++; hi_val = bus.pi_ad_out; if (!bus.pi_ad_oe) oe_bad++; end
            if (mode == 2'b01) begin lo_cyc++; lo_val = bus.pi_ad_out; if (!bus.pi_ad_oe) oe_bad++; end
            if ((s && mode != 2'b00) || (!bus.pi_read_n && !bus.pi_write_n)) bad_mode++;
            if (s) begin
                if (!strb_p) begin
                    cur_w = 0;
                    pulse_rd = !bus.pi_read_n;
                    if (strb > 0) gap_sum += cur_gap;
                    if (!bus.pi_write_n) wobs.push_back(bus.pi_ad_out);
                end
                cur_w++;
                if (!bus.pi_write_n) begin
                    if (bus.pi_ad_out !== wobs[$] || !bus.pi_ad_oe) wunstable++;
                end else begin
                    if (bus.pi_ad_oe) oe_bad++;
                    // Cartridge data is valid only in the back half of the pulse.
                    bus.pi_ad_in = (cur_w * 2 > PUL && rsrc_i < rsrc.size()) ? rsrc[rsrc_i] : 16'hDEAD;
                end
            end else if (strb_p) begin
                strb++;
                if (cur_w != PUL) width_bad++;
                if (pulse_rd) rsrc_i++;
                cur_gap = 1;
            end else if (mode == 2'b00) begin
                if (strb == 0) pre_cyc++; else cur_gap++;
            end
            if (pmode == 2'b00 && mode == 2'b10) post_cyc = cur_gap;
            if (bus.rdata_valid) robs.push_back(bus.rdata);
            if (bus.done) done_cnt++;
            pmode  = mode;
            strb_p = s;
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, " aleh"}, bus.pi_aleh, 1);
        check({tag, " alel"}, bus.pi_alel, 0);
        check({tag, " read_n"}, bus.pi_read_n, 1);
        check({tag, " write_n"}, bus.pi_write_n, 1);
        check({tag, " ad_oe"}, bus.pi_ad_oe, 0);
        check({tag, " ad_out"}, bus.pi_ad_out, 0);
        check({tag, " busy"}, bus.busy, 0);
        check({tag, " done"}, bus.done, 0);
        check({tag, " wdata_ready"}, bus.wdata_ready, 0);
        check({tag, " rdata_valid"}, bus.rdata_valid, 0);
        check({tag, " rdata"}, bus.rdata, 0);
    endtask

    task automatic start_txn(input string tag, input logic wr, input logic [31:0] a, input logic [7:0] len);
        @(negedge clk); #1;
        mon_clr = 1'b1; bus.write = wr; bus.address = a; bus.length = len; bus.req = 1'b1;
        @(negedge clk);
        check({tag, " busy_after_req"}, bus.busy, 1);
        #1;
        mon_clr = 1'b0; bus.req = 1'b0; bus.write = ~wr; bus.address = ~a; bus.length = ~len;
    endtask

    task automatic drive_words(input string tag, input int n, input int sw, input int st);
        for (int k = 0; k < n; k++) begin
            int g;
            if (k == sw) begin
                g = 0;
                while (!bus.wdata_ready && g < 5000) begin @(negedge clk); g++; end
                for (int i = 0; i < st; i++) begin
                    @(negedge clk);
                    check({tag, " stall_write_n_high"}, bus.pi_write_n, 1);
                    check({tag, " stall_mode_valid"}, {bus.pi_aleh, bus.pi_alel}, 2'b00);
                end
            end
            bus.wdata = wsrc[k];
            bus.wdata_valid = 1'b1;
            g = 0;
            while (!bus.wdata_ready && g < 5000) begin @(negedge clk); g++; end
            check({tag, " wready_in_time"}, g < 5000, 1);
            @(negedge clk);
            bus.wdata_valid = 1'b0;
        end
    endtask

    task automatic verify(input string tag, input vec_t v);
        int nw  = int'(v.len) + 1;
        int bad = 0;
        int exp_pre = LAT + ((v.wr && v.sw == 0) ? v.st : 0);
        int exp_gap = REL * int'(v.len) + ((v.wr && v.sw > 0 && v.sw <= int'(v.len)) ? v.st : 0);
        check({tag, " hi_addr"}, hi_val, v.exp_hi);
        check({tag, " lo_addr"}, lo_val, v.exp_lo);
        check({tag, " high_cycles"}, hi_cyc, ALE);
        check({tag, " low_cycles"}, lo_cyc, ALE);
        check({tag, " settle_cycles"}, pre_cyc, exp_pre);
        check({tag, " release_gap_total"}, gap_sum, exp_gap);
        check({tag, " final_release"}, post_cyc, REL);
        check({tag, " strobes"}, strb, nw);
        check({tag, " pulse_width_errors"}, width_bad, 0);
        check({tag, " mode_errors"}, bad_mode, 0);
        check({tag, " oe_errors"}, oe_bad, 0);
        check({tag, " done_pulses"}, done_cnt, 1);
        check({tag, " busy_idle"}, bus.busy, 0);
        if (v.wr) begin
            check({tag, " write_words"}, wobs.size(), nw);
            check({tag, " write_data_unstable"}, wunstable, 0);
            check({tag, " no_rdata_on_write"}, robs.size(), 0);
            for (int i = 0; i < wobs.size() && i < nw; i++) if (wobs[i] !== wsrc[i]) bad++;
        end else begin
            check({tag, " read_words"}, robs.size(), nw);
            for (int i = 0; i < robs.size() && i < nw; i++) if (robs[i] !== rsrc[i]) bad++;
        end
        check({tag, " data_mismatches"}, bad, 0);
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        start_txn(tag, v.wr, v.a, v.len);
        fork
            begin
                if (v.wr) drive_words(tag, int'(v.len) + 1, v.sw, v.st);
            end
            begin
                if (v.busy_pulse) begin
                    repeat (10) @(negedge clk);
                    #1 bus.req = 1'b1;
                    @(negedge clk);
                    #1 bus.req = 1'b0;
                end
            end
            begin
                int g = 0;
                while (!bus.done && g < TMO) begin @(negedge clk); g++; end
                check({tag, " done_in_time"}, g < TMO, 1);
            end
        join
        repeat (3) @(negedge clk);
        verify(tag, v);
        if (v.busy_pulse) begin
            int quiet = 0;
            repeat (30) begin
                @(negedge clk);
                if (bus.busy || bus.pi_alel || !bus.pi_aleh) quiet++;
            end
            check({tag, " req_while_busy_ignored"}, quiet, 0);
        end
    endtask

    task automatic fill_fixed(input logic [7:0] len);
        wsrc.delete(); rsrc.delete();
        for (int k = 0; k <= int'(len); k++) begin
            wsrc.push_back(16'(k + 1));
            rsrc.push_back(16'hBEEF + 16'(k) * 16'h0101);
        end
    endtask

    initial begin
        vec_t v;
        int   g;
        reset = 1'b0;
        bus.req = 1'b0; bus.write = 1'b0; bus.address = '0; bus.length = '0;
        bus.wdata = '0; bus.wdata_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("por");
        #1 reset = 1'b1;

        vecs[0] = '{1'b0, 32'h1000_0000, 8'd0,   -1, 0,  1'b0, 16'h1000, 16'h0000};
        vecs[1] = '{1'b1, 32'h1FFE_0002, 8'd3,   -1, 0,  1'b0, 16'h1FFE, 16'h0002};
        vecs[2] = '{1'b1, 32'h1000_0400, 8'd3,   2,  20, 1'b0, 16'h1000, 16'h0400};
        vecs[3] = '{1'b0, 32'h1000_0000, 8'd255, -1, 0,  1'b0, 16'h1000, 16'h0000};
        vecs[4] = '{1'b0, 32'h0800_0001, 8'd1,   -1, 0,  1'b1, 16'h0800, 16'h0000};
        vecs[5] = '{1'b1, 32'h1000_0010, 8'd1,   0,  20, 1'b0, 16'h1000, 16'h0010};

        for (int i = 0; i < 6; i++) begin
            fill_fixed(vecs[i].len);
            run_vec($sformatf("vec%0d", i), vecs[i]);
        end

        // Abort a read burst during its third strobe.
        fill_fixed(8'd7);
        start_txn("abort", 1'b0, 32'h1000_0000, 8'd7);
        g = 0;
        while (!(strb == 2 && !bus.pi_read_n) && g < 2000) begin @(negedge clk); g++; end
        check("abort reach_third_strobe", g < 2000, 1);
        #2 reset = 1'b0;
        #1 check_reset_outputs("abort");
        repeat (3) @(negedge clk);
        check_reset_outputs("abort_held");
        #1 reset = 1'b1;
        repeat (6) @(negedge clk);
        check("abort no_done", done_cnt, 0);
        check("abort stays_idle", bus.busy, 0);
        fill_fixed(vecs[0].len);
        run_vec("post_abort", vecs[0]);

        // Random bursts against the protocol model.
        for (int i = 0; i < 10; i++) begin
            v.wr  = 1'($urandom_range(0, 1));
            v.a   = $urandom;
            v.len = 8'($urandom_range(0, 6));
            v.sw  = (v.wr && $urandom_range(0, 1) == 1) ? $urandom_range(0, int'(v.len)) : -1;
            v.st  = $urandom_range(1, 12);
            v.busy_pulse = 1'b0;
            v.exp_hi = v.a[31:16];
            v.exp_lo = v.a[15:0] & 16'hFFFE;
            wsrc.delete(); rsrc.delete();
            for (int k = 0; k <= int'(v.len); k++) begin
                wsrc.push_back(16'($urandom));
                rsrc.push_back(16'($urandom));
            end
            run_vec($sformatf("rand%0d", i), v);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
